// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
// Module      : mem_stage
// Description : Memory stage of a pipelined core. Issues one registered
//               request per aligned load/store to a data memory. It stalls
//               the upstream pipeline while it waits for the single-cycle
//               acknowledge and abandons the access after TIMEOUT wait cycles.
//
// Ports       : CLK, RESET                  clock, synchronous active-high reset
//               MemtoRegM, MemWriteM        load / store qualifiers (store wins)
//               ALUOutM, WriteDataM         byte address and store data
//               MemAck, MemRData            memory completion pulse and read data
//               MemReq, MemWE               registered request / write enable
//               MemAddr, MemWData           registered word address / write data
//               ReadData                    load result towards MEM/WB
//               StallM                      freeze for upstream stages
//               AlignFaultM                 misaligned access in IDLE
//               TimeoutM                    access abandoned (one cycle, DONE)
//
// Revision    : 1.0  initial release
// ============================================================================
module mem_stage #(
    parameter int TIMEOUT = 15
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        MemtoRegM,
    input  logic        MemWriteM,
    input  logic [31:0] ALUOutM,
    input  logic [31:0] WriteDataM,
    input  logic        MemAck,
    input  logic [31:0] MemRData,
    output logic        MemReq,
    output logic        MemWE,
    output logic [31:0] MemAddr,
    output logic [31:0] MemWData,
    output logic [31:0] ReadData,
    output logic        StallM,
    output logic        AlignFaultM,
    output logic        TimeoutM
);

    localparam logic [1:0] c_IDLE     = 2'd0;
    localparam logic [1:0] c_WAIT     = 2'd1;
    localparam logic [1:0] c_DONE     = 2'd2;

    // Counter value on which an unanswered access is abandoned.
    localparam logic [3:0] c_CNT_LAST = 4'(TIMEOUT - 1);
    localparam logic [3:0] c_CNT_MAX  = 4'hF;

    logic [1:0]  r_state;
    logic [3:0]  r_cnt;
    logic [31:0] r_readData;
    logic        r_timeout;

    logic        w_access;
    logic        w_misaligned;
    logic        w_start;

    assign w_access     = MemtoRegM | MemWriteM;
    assign w_misaligned = (ALUOutM[1:0] != 2'b00);
    // An access is only launched from IDLE, and only when aligned.
    assign w_start      = (r_state == c_IDLE) && w_access && !w_misaligned;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state    <= c_IDLE;
            r_cnt      <= 4'd0;
            r_readData <= 32'd0;
            r_timeout  <= 1'b0;
            MemReq     <= 1'b0;
            MemWE      <= 1'b0;
            MemAddr    <= 32'd0;
            MemWData   <= 32'd0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_start) begin
                        MemAddr  <= {ALUOutM[31:2], 2'b00};
                        MemWData <= WriteDataM;
                        // A simultaneous load+store qualifier is a store.
                        MemWE    <= MemWriteM;
                        MemReq   <= 1'b1;
                        r_cnt    <= 4'd0;
                        r_state  <= c_WAIT;
                    end
                end
                c_WAIT: begin
                    // Acknowledge beats the timeout when both land together.
                    if (MemAck) begin
                        if (!MemWE) begin
                            r_readData <= MemRData;
                        end
                        MemReq  <= 1'b0;
                        r_state <= c_DONE;
                    end else if (r_cnt == c_CNT_LAST) begin
                        MemReq     <= 1'b0;
                        r_readData <= 32'd0;
                        r_timeout  <= 1'b1;
                        r_state    <= c_DONE;
                    end else if (r_cnt != c_CNT_MAX) begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                c_DONE: begin
                    // The same instruction is still presented here; it is
                    // not re-examined, the stage simply returns to IDLE.
                    r_timeout <= 1'b0;
                    r_state   <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        StallM      = 1'b0;
        AlignFaultM = 1'b0;
        TimeoutM    = 1'b0;
        ReadData    = r_readData;
        if (!RESET) begin
            case (r_state)
                c_IDLE: begin
                    StallM      = w_access && !w_misaligned;
                    AlignFaultM = w_access && w_misaligned;
                    // A faulting load hands zero to writeback.
                    if (w_access && w_misaligned) begin
                        ReadData = 32'd0;
                    end
                end
                c_WAIT: begin
                    StallM = 1'b1;
                end
                c_DONE: begin
                    TimeoutM = r_timeout;
                end
                default: begin
                    StallM = 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_stage
// Description : Self-checking bench for mem_stage. A driver presents one
//               instruction at a time and plays the data memory; expected
//               outcomes are derived from an instruction-level model and
//               queued; a monitor compares them when the stage releases.
// Revision    : 1.0  initial release
// ============================================================================
module tb_mem_stage;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        MemtoRegM;
    logic        MemWriteM;
    logic [31:0] ALUOutM;
    logic [31:0] WriteDataM;
    logic        MemAck;
    logic [31:0] MemRData;
    logic        MemReq;
    logic        MemWE;
    logic [31:0] MemAddr;
    logic [31:0] MemWData;
    logic [31:0] ReadData;
    logic        StallM;
    logic        AlignFaultM;
    logic        TimeoutM;

    always #5 CLK = ~CLK;

    mem_stage #(.TIMEOUT(15)) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .MemtoRegM  (MemtoRegM),
        .MemWriteM  (MemWriteM),
        .ALUOutM    (ALUOutM),
        .WriteDataM (WriteDataM),
        .MemAck     (MemAck),
        .MemRData   (MemRData),
        .MemReq     (MemReq),
        .MemWE      (MemWE),
        .MemAddr    (MemAddr),
        .MemWData   (MemWData),
        .ReadData   (ReadData),
        .StallM     (StallM),
        .AlignFaultM(AlignFaultM),
        .TimeoutM   (TimeoutM)
    );

    typedef struct {
        logic        chkRd;
        logic [31:0] rd;
        logic        to;
        logic        fault;
        int          stall;
        int          req;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        we;
    } exp_t;

    exp_t        q[$];
    int          checks   = 0;
    int          failures = 0;
    logic        scoreOn  = 1'b0;
    logic [31:0] modelReg = 32'd0;
    int          stallCnt = 0;
    int          reqCnt   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: per-cycle request checks while the front instruction waits,
    // full outcome check on the cycle the stage lets it go.
    always @(negedge CLK) begin
        if (scoreOn && !RESET && q.size() > 0) begin
            if (StallM) stallCnt++;
            if (MemReq) begin
                reqCnt++;
                chk("MemAddr", MemAddr, q[0].addr);
                chk("MemWData", MemWData, q[0].wdata);
                chk("MemWE", 32'(MemWE), 32'(q[0].we));
                chk("AlignFaultInWait", 32'(AlignFaultM), 32'd0);
            end
            if (!StallM) begin
                exp_t e;
                e = q.pop_front();
                if (e.chkRd) chk("ReadData", ReadData, e.rd);
                chk("TimeoutM", 32'(TimeoutM), 32'(e.to));
                chk("AlignFaultM", 32'(AlignFaultM), 32'(e.fault));
                chk("StallCycles", 32'(stallCnt), 32'(e.stall));
                chk("ReqCycles", 32'(reqCnt), 32'(e.req));
                stallCnt = 0;
                reqCnt   = 0;
            end
        end
    end

    // kind: bit0 = load qualifier, bit1 = store qualifier.
    // d: index of the wait cycle that gets the acknowledge; >=15 means never.
    task automatic runInst(input logic [1:0] kind, input logic [31:0] addr,
                           input logic [31:0] wdata, input int d,
                           input logic [31:0] rdata);
        exp_t e;
        int   waitIdx;
        int   guard;
        logic done;
        logic acc;
        logic aligned;
        int   w;
        MemtoRegM  = kind[0];
        MemWriteM  = kind[1];
        ALUOutM    = addr;
        WriteDataM = wdata;

        acc     = (kind != 2'b00);
        aligned = (addr[1:0] == 2'b00);
        e.addr  = {addr[31:2], 2'b00};
        e.wdata = wdata;
        e.we    = kind[1];
        e.to    = 1'b0;
        e.fault = acc && !aligned;
        e.stall = 0;
        e.req   = 0;
        e.chkRd = acc;
        e.rd    = 32'd0;
        if (acc && aligned) begin
            w       = (d >= 15) ? 15 : d + 1;
            e.stall = w + 1;
            e.req   = w;
            if (d >= 15) begin
                e.to     = 1'b1;
                modelReg = 32'd0;
            end else if (!kind[1]) begin
                modelReg = rdata;
            end
            e.rd = modelReg;
        end
        q.push_back(e);

        waitIdx = 0;
        guard   = 0;
        done    = 1'b0;
        while (!done) begin
            @(negedge CLK);
            if (MemReq) begin
                MemAck   = (waitIdx == d);
                MemRData = (waitIdx == d) ? rdata : $urandom;
                waitIdx++;
            end else begin
                // Stray acknowledges outside WAIT must be ignored.
                MemAck   = ($urandom_range(0, 3) == 0);
                MemRData = $urandom;
            end
            done = !StallM;
            guard++;
            if (!done && guard > 40) begin
                checks++;
                failures++;
                $display("FAIL stall_bound actual=%0d required<=40", guard);
                q.delete();
                stallCnt = 0;
                reqCnt   = 0;
                done     = 1'b1;
            end
            @(posedge CLK);
            #1;
        end
        MemAck = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout");
        $fatal(1, "global timeout");
    end

    initial begin
        RESET      = 1'b1;
        MemtoRegM  = 1'b1;
        MemWriteM  = 1'b0;
        ALUOutM    = 32'h0000_0103;
        WriteDataM = 32'd0;
        MemAck     = 1'b0;
        MemRData   = 32'd0;

        // Outputs forced low during reset, even with a misaligned load shown.
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk("rst_StallM", 32'(StallM), 32'd0);
        chk("rst_AlignFaultM", 32'(AlignFaultM), 32'd0);
        chk("rst_TimeoutM", 32'(TimeoutM), 32'd0);
        ALUOutM = 32'h0000_0100;
        @(negedge CLK);
        chk("rst_StallM_aligned", 32'(StallM), 32'd0);
        @(posedge CLK);
        #1;
        RESET     = 1'b0;
        MemtoRegM = 1'b0;
        @(negedge CLK);
        chk("rst_MemReq", 32'(MemReq), 32'd0);
        chk("rst_MemWE", 32'(MemWE), 32'd0);
        chk("rst_MemAddr", MemAddr, 32'd0);
        chk("rst_MemWData", MemWData, 32'd0);
        chk("idle_StallM", 32'(StallM), 32'd0);
        @(posedge CLK);
        #1;

        scoreOn = 1'b1;
        runInst(2'b01, 32'h0000_0100, 32'h0, 1, 32'hCAFE_F00D);    // load, ack in 2nd wait
        runInst(2'b10, 32'h0000_0200, 32'h1234_5678, 4, 32'hFFFF_FFFF); // store
        runInst(2'b01, 32'h0000_0103, 32'h0, 0, 32'h1111_1111);    // misaligned load
        runInst(2'b01, 32'h0000_0300, 32'h0, 99, 32'h0);           // never acked
        runInst(2'b01, 32'h0000_0304, 32'h0, 14, 32'hA5A5_A5A5);   // ack on last wait
        runInst(2'b11, 32'h0000_0408, 32'h5555_AAAA, 0, 32'h7777_7777); // both -> store
        runInst(2'b00, 32'h0000_0001, 32'h0, 0, 32'h0);            // no access

        // Reset while waiting: request drops, a later ack is stray.
        scoreOn    = 1'b0;
        MemtoRegM  = 1'b1;
        MemWriteM  = 1'b0;
        ALUOutM    = 32'h0000_0040;
        repeat (3) begin
            @(posedge CLK);
            #1;
        end
        RESET = 1'b1;
        @(negedge CLK);
        chk("rw_MemReq_before", 32'(MemReq), 32'd1);
        chk("rw_StallM_in_reset", 32'(StallM), 32'd0);
        @(posedge CLK);
        #1;
        RESET     = 1'b0;
        MemtoRegM = 1'b0;
        MemAck    = 1'b1;
        MemRData  = 32'hDEAD_BEEF;
        @(negedge CLK);
        chk("rw_MemReq_after", 32'(MemReq), 32'd0);
        chk("rw_StallM_after", 32'(StallM), 32'd0);
        @(posedge CLK);
        #1;
        MemAck = 1'b0;
        @(negedge CLK);
        chk("rw_MemReq_stray", 32'(MemReq), 32'd0);
        chk("rw_StallM_stray", 32'(StallM), 32'd0);
        @(posedge CLK);
        #1;
        modelReg = 32'd0;
        scoreOn  = 1'b1;
        runInst(2'b01, 32'h0000_0080, 32'h0, 2, 32'h1357_9BDF);

        // Randomized traffic.
        for (int i = 0; i < 150; i++) begin
            logic [1:0]  k;
            logic [31:0] a;
            int          d;
            int          sel;
            k = 2'($urandom_range(0, 3));
            a = $urandom;
            if ($urandom_range(0, 4) != 0) a[1:0] = 2'b00;
            sel = $urandom_range(0, 9);
            if (sel < 7)       d = $urandom_range(0, 5);
            else if (sel == 7) d = $urandom_range(12, 14);
            else if (sel == 8) d = 14;
            else               d = 20;
            runInst(k, a, $urandom, d, $urandom);
        end

        repeat (2) @(posedge CLK);
        chk("queue_empty", 32'(q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
